// File: rtl/frq_meter.sv
// Period meter: recovers the period of a slow asynchronous square wave in clk cycles.
// Define FRQ_METER_DUTY_EN to also measure the high time of each period.
module frq_meter #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             s_in,
  output logic [WIDTH-1:0] period,
  output logic             valid,
  output logic             locked,
  output logic             ovf
`ifdef FRQ_METER_DUTY_EN
  ,
  output logic [WIDTH-1:0] high_time
`endif
);

  typedef enum logic [1:0] {
    IDLE,
    ARM,
    MEASURE
  } state_t;

  // Last count value before a missing rise is declared an overflow.
  localparam logic [WIDTH-1:0] CNT_LAST = {{(WIDTH-1){1'b1}}, 1'b0};
  localparam logic [WIDTH-1:0] CNT_ONE  = WIDTH'(1);

  state_t           r_state;
  state_t           w_state_nxt;
  logic             r_sync1;
  logic             r_sync2;
  logic             r_sync3;
  logic [WIDTH-1:0] r_cnt;
  logic [WIDTH-1:0] r_period;
  logic             r_valid;
  logic             r_locked;
  logic             r_ovf;
  logic             w_rise;
  logic             w_meas_done;
  logic             w_ovf_hit;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sync1 <= 1'b0;
      r_sync2 <= 1'b0;
      r_sync3 <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments let every flop sample the pre-edge value,
      // which is what makes this a three-stage shift rather than one flop.
      r_sync1 <= s_in;
      r_sync2 <= r_sync1;
      r_sync3 <= r_sync2;
    end
  end

  assign w_rise      = r_sync2 & ~r_sync3;
  assign w_meas_done = (r_state == MEASURE) && en && w_rise;
  assign w_ovf_hit   = (r_state == MEASURE) && en && !w_rise && (r_cnt == CNT_LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    // NOTE: default first so every path assigns w_state_nxt and no latch is inferred.
    w_state_nxt = r_state;
    if (!en) begin
      w_state_nxt = IDLE;
    end else begin
      case (r_state)
        IDLE:    w_state_nxt = ARM;
        ARM:     if (w_rise) w_state_nxt = MEASURE;
        MEASURE: if (w_ovf_hit) w_state_nxt = ARM;
        default: w_state_nxt = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt    <= '0;
      r_period <= '0;
      r_valid  <= 1'b0;
      r_locked <= 1'b0;
      r_ovf    <= 1'b0;
    end else begin
      r_valid <= w_meas_done;
      r_ovf   <= w_ovf_hit;

      if (!en || (r_state != MEASURE) || w_rise || w_ovf_hit) r_cnt <= '0;
      else                                                   r_cnt <= r_cnt + CNT_ONE;

      if (w_meas_done) r_period <= r_cnt + CNT_ONE;

      if (!en || w_ovf_hit || (r_state == IDLE)) r_locked <= 1'b0;
      else if (w_meas_done)                      r_locked <= 1'b1;
    end
  end

  assign period = r_period;
  assign valid  = r_valid;
  assign locked = r_locked;
  assign ovf    = r_ovf;

`ifdef FRQ_METER_DUTY_EN
  logic             w_fall;
  logic             r_fall_seen;
  logic [WIDTH-1:0] r_hcnt;
  logic [WIDTH-1:0] r_high_time;

  assign w_fall = ~r_sync2 & r_sync3;

  // A period with no fall is a stuck-high input; report the whole period as high.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_fall_seen <= 1'b0;
      r_hcnt      <= '0;
      r_high_time <= '0;
    end else begin
      if (!en || (r_state != MEASURE) || w_rise) begin
        r_fall_seen <= 1'b0;
      end else if (w_fall) begin
        r_fall_seen <= 1'b1;
        r_hcnt      <= r_cnt + CNT_ONE;
      end
      if (w_meas_done) r_high_time <= r_fall_seen ? r_hcnt : (r_cnt + CNT_ONE);
    end
  end

  assign high_time = r_high_time;
`endif

endmodule

// File: tb/tb_frq_meter.sv
// Directed bench for frq_meter: a WIDTH=16 instance for the main scenarios and a
// WIDTH=4 instance for overflow behaviour.
module tb_frq_meter;

  typedef struct {
    int per;
    int hi;
    int due;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        en;
  logic        s_in;
  logic [15:0] period;
  logic        valid;
  logic        locked;
  logic        ovf;
  logic        en4;
  logic        s_in4;
  logic [3:0]  period4;
  logic        valid4;
  logic        locked4;
  logic        ovf4;
`ifdef FRQ_METER_DUTY_EN
  logic [15:0] high_time;
  logic [3:0]  high_time4;
`endif

  frq_meter #(.WIDTH(16)) dut (
    .clk(clk), .rst_n(rst_n), .en(en), .s_in(s_in),
    .period(period), .valid(valid), .locked(locked), .ovf(ovf)
`ifdef FRQ_METER_DUTY_EN
    , .high_time(high_time)
`endif
  );

  frq_meter #(.WIDTH(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .en(en4), .s_in(s_in4),
    .period(period4), .valid(valid4), .locked(locked4), .ovf(ovf4)
`ifdef FRQ_METER_DUTY_EN
    , .high_time(high_time4)
`endif
  );

  always #5 clk = ~clk;

  int   n_chk = 0;
  int   n_err = 0;
  int   cyc_n = 0;
  int   first_valid = -1;
  int   n_ovf = 0;
  int   n_both = 0;
  int   n4_valid = 0;
  int   n4_ovf = 0;
  int   last4_valid = -1;
  int   ovf4_cyc = -1;
  int   prev_rise = -1;
  int   fall_hi = 0;
  bit   fall_seen_m = 1'b0;
  logic s_prev = 1'b0;
  exp_t q[$];

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, act, exp, cyc_n);
    end
  endtask

  // Advance one clock and compare every valid against the drive-side model.
  task automatic cyc();
    exp_t e;
    @(posedge clk);
    #1;
    cyc_n++;
    if (valid) begin
      if (first_valid < 0) first_valid = cyc_n;
      if (q.size() == 0) begin
        check("spurious_valid", 32'(valid), 0);
      end else begin
        e = q.pop_front();
        check("period", 32'(period), e.per);
        check("valid_cycle", cyc_n, e.due);
`ifdef FRQ_METER_DUTY_EN
        check("high_time", 32'(high_time), e.hi);
`endif
      end
    end
    if (ovf) n_ovf++;
    if (valid && ovf) n_both++;
    if (valid4) begin
      n4_valid++;
      last4_valid = cyc_n;
    end
    if (ovf4) begin
      n4_ovf++;
      ovf4_cyc = cyc_n;
    end
    if (valid4 && ovf4) n_both++;
  endtask

  task automatic model_clear();
    q.delete();
    prev_rise   = -1;
    fall_seen_m = 1'b0;
  endtask

  // A rise driven now closes the previous period; its valid shows three cycles later.
  task automatic step(input logic s);
    exp_t e;
    if (s && !s_prev) begin
      if (prev_rise >= 0) begin
        e.per = cyc_n - prev_rise;
        e.hi  = fall_seen_m ? fall_hi : e.per;
        e.due = cyc_n + 3;
        q.push_back(e);
      end
      prev_rise   = cyc_n;
      fall_seen_m = 1'b0;
    end
    if (!s && s_prev && prev_rise >= 0) begin
      fall_hi     = cyc_n - prev_rise;
      fall_seen_m = 1'b1;
    end
    s_in   = s;
    s_prev = s;
    cyc();
  endtask

  task automatic period_wave(input int h, input int l);
    repeat (h) step(1'b1);
    repeat (l) step(1'b0);
  endtask

  task automatic restart();
    repeat (4) step(1'b0);
    en = 1'b0;
    model_clear();
    step(1'b0);
    step(1'b0);
    check("restart_locked", 32'(locked), 0);
    en = 1'b1;
    step(1'b0);
    step(1'b0);
  endtask

  initial begin
    int c0;
    int c1;
    rst_n = 1'b1;
    en    = 1'b0;
    s_in  = 1'b0;
    en4   = 1'b0;
    s_in4 = 1'b0;
    #1 rst_n = 1'b0;
    #7;
    check("rst_period", 32'(period), 0);
    check("rst_valid", 32'(valid), 0);
    check("rst_locked", 32'(locked), 0);
    check("rst_ovf", 32'(ovf), 0);
    check("rst_period4", 32'(period4), 0);
    #4 rst_n = 1'b1;

    // High 3 / low 5: first valid after the second rise, period 8 thereafter.
    en = 1'b1;
    step(1'b0);
    step(1'b0);
    model_clear();
    first_valid = -1;
    c0 = cyc_n;
    repeat (6) period_wave(3, 5);
    check("t1_first_valid_lat", first_valid - c0, 11);
    check("t1_period", 32'(period), 8);
    check("t1_locked", 32'(locked), 1);
`ifdef FRQ_METER_DUTY_EN
    check("t1_high_time", 32'(high_time), 3);
`endif

    // Divide-by-5 input.
    restart();
    repeat (8) period_wave(2, 3);
    repeat (4) step(1'b0);
    check("t2_period", 32'(period), 5);
    check("t2_all_valids", q.size(), 0);
    check("t2_no_ovf", n_ovf, 0);

    // One-cycle enable drop mid-period.
    restart();
    repeat (3) period_wave(3, 5);
    check("t4_locked_before", 32'(locked), 1);
    repeat (3) step(1'b1);
    repeat (2) step(1'b0);
    en = 1'b0;
    model_clear();
    step(1'b0);
    en = 1'b1;
    repeat (2) step(1'b0);
    check("t4_locked_dropped", 32'(locked), 0);
    check("t4_period_held", 32'(period), 8);
    period_wave(3, 5);
    check("t4_locked_arm_only", 32'(locked), 0);
    check("t4_period_held2", 32'(period), 8);
    period_wave(3, 5);
    check("t4_locked_again", 32'(locked), 1);
    check("t4_period_again", 32'(period), 8);

    // Asynchronous reset in the middle of a measurement.
    repeat (3) step(1'b1);
    repeat (2) step(1'b0);
    #3 rst_n = 1'b0;
    #1;
    check("t5_rst_period", 32'(period), 0);
    check("t5_rst_valid", 32'(valid), 0);
    check("t5_rst_locked", 32'(locked), 0);
    model_clear();
    #2 rst_n = 1'b1;
    repeat (3) step(1'b0);
    repeat (4) period_wave(3, 5);
    repeat (4) step(1'b0);
    check("t5_period", 32'(period), 8);
    check("t5_locked", 32'(locked), 1);
    check("t5_all_valids", q.size(), 0);

    // Period changes 6 -> 11 -> 2.
    restart();
    repeat (4) period_wave(3, 3);
    repeat (4) period_wave(5, 6);
    repeat (6) period_wave(1, 1);
    repeat (4) step(1'b0);
    check("t6_period", 32'(period), 2);
    check("t6_all_valids", q.size(), 0);

    // WIDTH=4: period 15 is the largest measurable, then a stuck-low input overflows.
    en4 = 1'b1;
    cyc();
    cyc();
    c0 = cyc_n;
    repeat (3) begin
      s_in4 = 1'b1;
      repeat (7) cyc();
      s_in4 = 1'b0;
      repeat (8) cyc();
    end
    check("w4_valids", n4_valid, 2);
    check("w4_last_valid", last4_valid - c0, 33);
    check("w4_period", 32'(period4), 15);
    check("w4_locked", 32'(locked4), 1);
    check("w4_no_ovf_yet", n4_ovf, 0);
    repeat (20) cyc();
    check("w4_ovf_count", n4_ovf, 1);
    check("w4_ovf_cycle", ovf4_cyc - c0, 48);
    check("w4_locked_lost", 32'(locked4), 0);
    check("w4_no_valid", n4_valid, 2);
    check("w4_period_held", 32'(period4), 15);
    c1 = cyc_n;
    repeat (2) begin
      s_in4 = 1'b1;
      repeat (7) cyc();
      s_in4 = 1'b0;
      repeat (8) cyc();
    end
    check("w4_relock_valids", n4_valid, 3);
    check("w4_relock_cycle", last4_valid - c1, 18);
    check("w4_relock_period", 32'(period4), 15);
    check("w4_relock_locked", 32'(locked4), 1);
    check("w4_relock_ovf", n4_ovf, 1);

    check("no_ovf_16", n_ovf, 0);
    check("valid_ovf_exclusive", n_both, 0);
    check("no_pending_valids", q.size(), 0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
